// File: rtl/hazard3_reg_bypass_pkg.sv
// hazard3_reg_bypass_pkg
// Shared configuration for the register-bypass block: default data and
// address widths, the x0 register index, and the per-port operand source
// encoding used by hazard3_reg_bypass_port.
package hazard3_reg_bypass_pkg;

  localparam int unsigned HZ3_W_DATA = 32;
  localparam int unsigned HZ3_W_ADDR = 5;
  localparam int unsigned HZ3_REG_X0 = 0;

  // Which source wins operand resolution for one read port.
  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_X    = 3'd1,
    SRC_M    = 3'd2,
    SRC_FIX  = 3'd3,
    SRC_RF   = 3'd4
  } bypass_src_t;

endpackage

// File: rtl/hazard3_reg_bypass_port.sv
// hazard3_reg_bypass_port
// One operand read port: steers the synchronous-read register file address,
// captures the address being read, catches a writeback that collides with
// that read, and resolves the operand from execute / memory / collision
// fix-up / register file with the matching stall flag.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   d_raddr, d_advance          decode-stage source address and advance strobe
//   rf_raddr (out), rf_rdata    register file read address / data (1-cycle)
//   wb_waddr, wb_wdata, wb_wen  writeback port (parallel to register file)
//   x_rd, x_wen, x_valid, x_result  execute-stage bypass source
//   m_rd, m_wen, m_valid, m_result  memory-stage bypass source
//   op (out), stall (out)       resolved operand and not-ready flag
module hazard3_reg_bypass_port
  import hazard3_reg_bypass_pkg::*;
#(
  parameter int unsigned W_DATA = HZ3_W_DATA,
  parameter int unsigned W_ADDR = HZ3_W_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] d_raddr,
  input  logic              d_advance,
  output logic [W_ADDR-1:0] rf_raddr,
  input  logic [W_DATA-1:0] rf_rdata,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] x_rd,
  input  logic              x_wen,
  input  logic              x_valid,
  input  logic [W_DATA-1:0] x_result,
  input  logic [W_ADDR-1:0] m_rd,
  input  logic              m_wen,
  input  logic              m_valid,
  input  logic [W_DATA-1:0] m_result,
  output logic [W_DATA-1:0] op,
  output logic              stall
);

  localparam logic [W_ADDR-1:0] X0 = W_ADDR'(HZ3_REG_X0);

  logic [W_ADDR-1:0] q_raddr_r;
  logic [W_DATA-1:0] fix_r;
  logic              fix_vld_r;
  logic              collide_s;
  bypass_src_t       src_s;

  // While the operand stage holds, keep re-reading the held register so a
  // writeback landing mid-stall reaches the register file output.
  assign rf_raddr  = d_advance ? d_raddr : q_raddr_r;

  // The register file reads before it writes in the same edge, so a write to
  // the address being read has to be caught here instead.
  assign collide_s = wb_wen && (wb_waddr == rf_raddr) && (wb_waddr != X0);

  // Address capture and writeback collision fix-up register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_raddr_r <= {W_ADDR{1'b0}};
      fix_r     <= {W_DATA{1'b0}};
      fix_vld_r <= 1'b0;
    end else begin
      q_raddr_r <= rf_raddr;
      if (collide_s) begin
        fix_r     <= wb_wdata;
        fix_vld_r <= 1'b1;
      end else begin
        fix_vld_r <= 1'b0;
      end
    end
  end

  // Pick the youngest source holding the register; a younger stage shadows
  // older ones even when its result is not ready yet.
  always_comb begin
    src_s = SRC_RF;
    if (q_raddr_r == X0) begin
      src_s = SRC_ZERO;
    end else if (x_wen && (x_rd == q_raddr_r)) begin
      src_s = SRC_X;
    end else if (m_wen && (m_rd == q_raddr_r)) begin
      src_s = SRC_M;
    end else if (fix_vld_r) begin
      src_s = SRC_FIX;
    end else begin
      src_s = SRC_RF;
    end
  end

  // Operand mux and stall for the winning source.
  always_comb begin
    op    = {W_DATA{1'b0}};
    stall = 1'b0;
    case (src_s)
      SRC_ZERO: begin
        op    = {W_DATA{1'b0}};
        stall = 1'b0;
      end
      SRC_X: begin
        op    = x_result;
        stall = !x_valid;
      end
      SRC_M: begin
        op    = m_result;
        stall = !m_valid;
      end
      SRC_FIX: begin
        op    = fix_r;
        stall = 1'b0;
      end
      SRC_RF: begin
        op    = rf_rdata;
        stall = 1'b0;
      end
      default: begin
        op    = rf_rdata;
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard3_reg_bypass.sv
// hazard3_reg_bypass
// Operand bypass for a synchronous-read register file. Two identical read
// ports resolve op1/op2 from execute, memory, writeback collision or the
// register file; op_stall asks the operand stage to hold when a needed
// result is not ready. Holds no register file storage.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   d_raddr1/2, d_advance               decode source addresses, advance strobe
//   rf_raddr1/2 (out), rf_rdata1/2      register file read ports
//   wb_waddr, wb_wdata, wb_wen          writeback port
//   x_rd, x_wen, x_valid, x_result      execute-stage bypass source
//   m_rd, m_wen, m_valid, m_result      memory-stage bypass source
//   op1, op2, op_stall (out)            resolved operands and stall
module hazard3_reg_bypass
  import hazard3_reg_bypass_pkg::*;
#(
  parameter int unsigned W_DATA = HZ3_W_DATA,
  parameter int unsigned W_ADDR = HZ3_W_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] d_raddr1,
  input  logic [W_ADDR-1:0] d_raddr2,
  input  logic              d_advance,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] x_rd,
  input  logic              x_wen,
  input  logic              x_valid,
  input  logic [W_DATA-1:0] x_result,
  input  logic [W_ADDR-1:0] m_rd,
  input  logic              m_wen,
  input  logic              m_valid,
  input  logic [W_DATA-1:0] m_result,
  output logic [W_DATA-1:0] op1,
  output logic [W_DATA-1:0] op2,
  output logic              op_stall
);

  logic stall1_s;
  logic stall2_s;

  hazard3_reg_bypass_port #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_port1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_raddr  (d_raddr1),
    .d_advance(d_advance),
    .rf_raddr (rf_raddr1),
    .rf_rdata (rf_rdata1),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .wb_wen   (wb_wen),
    .x_rd     (x_rd),
    .x_wen    (x_wen),
    .x_valid  (x_valid),
    .x_result (x_result),
    .m_rd     (m_rd),
    .m_wen    (m_wen),
    .m_valid  (m_valid),
    .m_result (m_result),
    .op       (op1),
    .stall    (stall1_s)
  );

  hazard3_reg_bypass_port #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_port2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_raddr  (d_raddr2),
    .d_advance(d_advance),
    .rf_raddr (rf_raddr2),
    .rf_rdata (rf_rdata2),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .wb_wen   (wb_wen),
    .x_rd     (x_rd),
    .x_wen    (x_wen),
    .x_valid  (x_valid),
    .x_result (x_result),
    .m_rd     (m_rd),
    .m_wen    (m_wen),
    .m_valid  (m_valid),
    .m_result (m_result),
    .op       (op2),
    .stall    (stall2_s)
  );

  assign op_stall = stall1_s | stall2_s;

endmodule

// File: doc/hazard3_reg_bypass.md
HAZARD3_REG_BYPASS -- requirements
Module: hazard3_reg_bypass

Interface
REQ-001 Parameter W_DATA, default 32, sets the register data width.
REQ-002 Parameter W_ADDR, default 5, sets the register address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 d_raddr1, d_raddr2  in  W_ADDR  decode-stage source register addresses.
REQ-006 d_advance  in  1  decode hands its instruction to the operand stage this cycle.
REQ-007 rf_raddr1, rf_raddr2  out  W_ADDR  read addresses driven to the synchronous-read register file.
REQ-008 rf_rdata1, rf_rdata2  in  W_DATA  register file read data, valid one cycle after the address.
REQ-009 wb_waddr, wb_wdata, wb_wen  in  W_ADDR/W_DATA/1  writeback port, wired in parallel to the register file write port.
REQ-010 x_rd, x_wen, x_valid, x_result  in  W_ADDR/1/1/W_DATA  execute-stage destination, write intent, result-ready flag and result.
REQ-011 m_rd, m_wen, m_valid, m_result  in  W_ADDR/1/1/W_DATA  memory-stage destination, write intent, result-ready flag and result.
REQ-012 op1, op2  out  W_DATA  resolved operands for the instruction held in the operand stage.
REQ-013 op_stall  out  1  an operand is not yet available; the operand stage must hold.

Function
REQ-014 rf_raddrN SHALL equal d_raddrN when d_advance=1, else q_raddrN (captured address), so the register file re-reads the held register during a stall.
REQ-015 q_raddrN SHALL load rf_raddrN on every rising edge.
REQ-016 Operand latency SHALL be one cycle: opN resolves q_raddrN in the cycle after capture, combinationally from state and current bypass inputs.
REQ-017 Collision capture: if wb_wen=1, wb_waddr=rf_raddrN and wb_waddr!=0 at an edge, then wb_wdata SHALL be stored in fixN and fixN_vld set; otherwise fixN_vld SHALL clear.
REQ-018 Resolution priority per port: q_raddrN=0 -> zero; else execute match (x_wen && x_rd=q_raddrN) -> x_result; else memory match -> m_result; else fixN_vld -> fixN; else rf_rdataN.
REQ-019 op_stall SHALL be 1 when, for either port with q_raddrN!=0, the winning match in REQ-018 is execute with x_valid=0 or memory with m_valid=0.
REQ-020 A younger stage match SHALL shadow an older one even when the younger result is not valid (stall, never older data).
REQ-021 Both ports reading the same register SHALL resolve identically.
REQ-022 Register x0 SHALL never match any bypass source and never stall.
REQ-023 During op_stall, captured addresses and fix registers SHALL keep tracking per REQ-014..017, so a writeback landing mid-stall is picked up without loss.

Reset
REQ-024 On rst_n low: q_raddr1=q_raddr2=0, fix1=fix2=0, fix1_vld=fix2_vld=0, asynchronously.
REQ-025 Consequently op1=op2=0 and op_stall=0 during and immediately after reset, regardless of bypass inputs.
REQ-026 Reset asserted mid-stall SHALL discard the held instruction's addresses; no state survives reset.

Structure
REQ-027 Widths and the x0 address constant SHALL come from the shared Hazard3 config include; no local magic numbers.
REQ-028 Per-port resolution (REQ-014..022) SHALL be one sub-module, hazard3_reg_bypass_port, instantiated twice; the top SHALL OR the per-port stall outputs.
REQ-029 No register file storage SHALL exist in this block.

Verification
REQ-030 Capture r5 on both ports; rf returns 0x1234 -> op1=op2=0x1234, op_stall=0.
REQ-031 Capture r7 while wb writes r7=0xCAFE in the same edge; rf returns stale 0x0 -> op1=0xCAFE.
REQ-032 q_raddr1=r3; x_rd=3, x_wen=1, x_valid=0, m_rd=3, m_valid=1, m_result=0x11 -> op_stall=1; next cycle x_valid=1, x_result=0x22 -> op1=0x22, op_stall=0.
REQ-033 q_raddr2=r0; x_rd=0, x_wen=1, x_valid=0 -> op2=0, op_stall=0.
REQ-034 Stall 3 cycles on r9 (d_advance=0); wb writes r9=0xBEEF in cycle 2 -> rf_raddr2 stays 9, op2=0xBEEF from cycle 3.
REQ-035 Assert rst_n low during a stall -> op1=op2=0 and op_stall=0 within the same cycle, remaining so after release.
